// File: rtl/alu_exec_unit_if.sv
// Handshake bundle between the ID/EX operand source, the execute ALU and the EX/MEM consumer.
interface alu_exec_unit_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [3:0]            operation;
  logic [DATA_WIDTH-1:0] src_a;
  logic [DATA_WIDTH-1:0] src_b;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] result;
  logic                  branch_taken;
  logic                  illegal_op;

  modport master (
    output in_valid, operation, src_a, src_b, out_ready,
    input  in_ready, out_valid, result, branch_taken, illegal_op
  );

  modport slave (
    input  in_valid, operation, src_a, src_b, out_ready,
    output in_ready, out_valid, result, branch_taken, illegal_op
  );
endinterface

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle logic/arith/compare ops, iterative shifter that stalls
// the input side, and a registered valid/ready result slot.
module alu_exec_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int SHIFT_STEP = 1
) (
  input logic            clk,
  input logic            rst_n,
  input logic            flush,
  alu_exec_unit_if.slave bus
);
  localparam int SHW = $clog2(DATA_WIDTH);
  localparam int CW  = SHW + 1;
  localparam logic [CW-1:0] STEP_C = CW'(SHIFT_STEP);

  typedef enum logic {IDLE, SHIFT} state_t;
  typedef enum logic [1:0] {K_SLL, K_SRL, K_SRA} kind_t;

  state_t                state, next_state;
  kind_t                 kind;
  logic [DATA_WIDTH-1:0] acc;
  logic [CW-1:0]         count;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] result;
  logic                  branch_taken;
  logic                  illegal_op;

  logic                  in_ready;
  logic                  accept;
  logic [SHW-1:0]        shamt;
  logic                  is_shift;
  logic [DATA_WIDTH-1:0] alu_res;
  logic                  cond;
  logic                  bad_op;
  logic [CW-1:0]         step;
  logic [DATA_WIDTH-1:0] shifted;

  assign shamt    = bus.src_b[SHW-1:0];
  assign is_shift = (bus.operation inside {4'd6, 4'd7, 4'd8});
  assign accept   = bus.in_valid && in_ready;

  // Single-cycle result; a zero-distance shift degenerates to a pass-through of src_a
  always_comb begin
    alu_res = '0;
    cond    = 1'b0;
    bad_op  = 1'b0;
    case (bus.operation)
      4'd1:  alu_res = bus.src_a + bus.src_b;
      4'd2:  alu_res = bus.src_a - bus.src_b;
      4'd3:  alu_res = bus.src_a ^ bus.src_b;
      4'd4:  alu_res = bus.src_a | bus.src_b;
      4'd5:  alu_res = bus.src_a & bus.src_b;
      4'd6, 4'd7, 4'd8: alu_res = bus.src_a;
      4'd9:  cond = (bus.src_a == bus.src_b);
      4'd10: cond = (bus.src_a != bus.src_b);
      4'd11: cond = ($signed(bus.src_a) <  $signed(bus.src_b));
      4'd12: cond = ($signed(bus.src_a) >= $signed(bus.src_b));
      default: bad_op = 1'b1;
    endcase
    if (cond) alu_res = DATA_WIDTH'(1);
  end

  always_comb begin
    step    = (count < STEP_C) ? count : STEP_C;
    shifted = acc;
    case (kind)
      K_SLL:   shifted = acc << step;
      K_SRL:   shifted = acc >> step;
      K_SRA:   shifted = DATA_WIDTH'($signed(acc) >>> step);
      default: shifted = acc;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (flush) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:    if (accept && is_shift && shamt != '0) next_state = SHIFT;
        SHIFT:   if (count == step) next_state = IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready = (state == IDLE) && !flush && (!out_valid || bus.out_ready);
  end

  // Output slot and shifter datapath; a finishing shift never collides with a held result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kind         <= K_SLL;
      acc          <= '0;
      count        <= '0;
      out_valid    <= 1'b0;
      result       <= '0;
      branch_taken <= 1'b0;
      illegal_op   <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
      count     <= '0;
    end else begin
      if (out_valid && bus.out_ready) out_valid <= 1'b0;
      if (state == IDLE && accept) begin
        if (is_shift && shamt != '0) begin
          acc   <= bus.src_a;
          count <= CW'(shamt);
          kind  <= (bus.operation == 4'd6) ? K_SLL :
                   (bus.operation == 4'd7) ? K_SRL : K_SRA;
        end else begin
          result       <= alu_res;
          branch_taken <= cond;
          illegal_op   <= bad_op;
          out_valid    <= 1'b1;
        end
      end else if (state == SHIFT) begin
        acc   <= shifted;
        count <= count - step;
        if (count == step) begin
          result       <= shifted;
          branch_taken <= 1'b0;
          illegal_op   <= 1'b0;
          out_valid    <= 1'b1;
        end
      end
    end
  end

  assign bus.in_ready     = in_ready;
  assign bus.out_valid    = out_valid;
  assign bus.result       = result;
  assign bus.branch_taken = branch_taken;
  assign bus.illegal_op   = illegal_op;
endmodule

// File: tb/tb_alu_exec_unit.sv
// Drives two ALU instances (4-bit and 1-bit shift steps) with directed and random operations
// and compares against an arithmetic reference of the instruction set.
module tb_alu_exec_unit;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          flush;
  logic          sel;
  logic          in_valid;
  logic          out_ready;
  logic [3:0]    operation;
  logic [DW-1:0] src_a;
  logic [DW-1:0] src_b;
  int            errors = 0;
  int            checks = 0;

  alu_exec_unit_if #(.DATA_WIDTH(DW)) bus4();
  alu_exec_unit_if #(.DATA_WIDTH(DW)) bus1();

  wire flush4 = flush & ~sel;
  wire flush1 = flush & sel;

  assign bus4.in_valid  = in_valid & ~sel;
  assign bus1.in_valid  = in_valid & sel;
  assign bus4.operation = operation;
  assign bus1.operation = operation;
  assign bus4.src_a     = src_a;
  assign bus1.src_a     = src_a;
  assign bus4.src_b     = src_b;
  assign bus1.src_b     = src_b;
  assign bus4.out_ready = out_ready;
  assign bus1.out_ready = out_ready;

  alu_exec_unit #(.DATA_WIDTH(DW), .SHIFT_STEP(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .flush(flush4), .bus(bus4)
  );
  alu_exec_unit #(.DATA_WIDTH(DW), .SHIFT_STEP(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush1), .bus(bus1)
  );

  wire          m_in_ready  = sel ? bus1.in_ready     : bus4.in_ready;
  wire          m_out_valid = sel ? bus1.out_valid    : bus4.out_valid;
  wire [DW-1:0] m_result    = sel ? bus1.result       : bus4.result;
  wire          m_branch    = sel ? bus1.branch_taken : bus4.branch_taken;
  wire          m_illegal   = sel ? bus1.illegal_op   : bus4.illegal_op;

  // Reference: {illegal, taken, result} straight from the opcode table
  function automatic logic [DW+1:0] model(input logic [3:0] op, input logic [DW-1:0] a,
                                          input logic [DW-1:0] b);
    int            sh;
    logic [DW-1:0] r;
    logic          t;
    logic          ill;
    sh  = int'(b % DW);
    r   = '0;
    t   = 1'b0;
    ill = 1'b0;
    case (op)
      1:  r = a + b;
      2:  r = a - b;
      3:  r = a ^ b;
      4:  r = a | b;
      5:  r = a & b;
      6:  r = a << sh;
      7:  r = a >> sh;
      8:  r = $signed(a) >>> sh;
      9:  t = (a == b);
      10: t = (a != b);
      11: t = ($signed(a) < $signed(b));
      12: t = ($signed(a) >= $signed(b));
      default: ill = 1'b1;
    endcase
    if (op >= 9 && op <= 12) r = {31'd0, t};
    return {ill, t, r};
  endfunction

  function automatic int latency(input logic [3:0] op, input logic [DW-1:0] b, input int stp);
    int sh;
    sh = int'(b % DW);
    if (op >= 6 && op <= 8 && sh != 0) return 1 + (sh + stp - 1) / stp;
    return 1;
  endfunction

  task automatic check_output(input string tag, input logic [DW-1:0] obs,
                              input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction with out_ready held high: accept, busy cycles, then result
  task automatic apply_stimulus(input logic s, input logic [3:0] op, input logic [DW-1:0] a,
                                input logic [DW-1:0] b);
    logic [DW+1:0] exp;
    int            lat;
    exp       = model(op, a, b);
    lat       = latency(op, b, s ? 1 : 4);
    sel       = s;
    operation = op;
    src_a     = a;
    src_b     = b;
    in_valid  = 1'b1;
    #1;
    check_output("accept_ready", DW'(m_in_ready), DW'(1));
    tick();
    in_valid = 1'b0;
    for (int k = 1; k < lat; k++) begin
      check_output("busy_valid", DW'(m_out_valid), DW'(0));
      check_output("busy_ready", DW'(m_in_ready), DW'(0));
      tick();
    end
    check_output("done_valid", DW'(m_out_valid), DW'(1));
    check_output("result", m_result, exp[DW-1:0]);
    check_output("branch", DW'(m_branch), DW'(exp[DW]));
    check_output("illegal", DW'(m_illegal), DW'(exp[DW+1]));
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    sel       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    operation = '0;
    src_a     = '0;
    src_b     = '0;
    #12;
    check_output("rst_valid", DW'(m_out_valid), DW'(0));
    check_output("rst_result", m_result, '0);
    check_output("rst_branch", DW'(m_branch), DW'(0));
    check_output("rst_illegal", DW'(m_illegal), DW'(0));
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    apply_stimulus(1'b0, 4'd1, 32'd5, 32'd7);
    apply_stimulus(1'b0, 4'd2, 32'd0, 32'd1);
    apply_stimulus(1'b0, 4'd11, 32'hFFFF_FFFF, 32'd1);
    apply_stimulus(1'b0, 4'd12, 32'd3, 32'd3);
    apply_stimulus(1'b0, 4'd13, 32'd9, 32'd4);
    apply_stimulus(1'b0, 4'd6, 32'd1, 32'd31);
    apply_stimulus(1'b0, 4'd7, 32'hDEAD_BEEF, 32'h0000_0100);
    apply_stimulus(1'b1, 4'd8, 32'h8000_0000, 32'd4);
    check_output("sra_value", m_result, 32'hF800_0000);

    // Held result must not move and must block a pending request
    sel       = 1'b0;
    out_ready = 1'b0;
    operation = 4'd1;
    src_a     = 32'd100;
    src_b     = 32'd23;
    in_valid  = 1'b1;
    #1;
    check_output("bp_accept", DW'(m_in_ready), DW'(1));
    tick();
    operation = 4'd2;
    src_a     = 32'd50;
    src_b     = 32'd8;
    for (int k = 0; k < 3; k++) begin
      #1;
      check_output("bp_hold_valid", DW'(m_out_valid), DW'(1));
      check_output("bp_hold_result", m_result, 32'd123);
      check_output("bp_hold_ready", DW'(m_in_ready), DW'(0));
      tick();
    end
    out_ready = 1'b1;
    #1;
    check_output("bp_drain_ready", DW'(m_in_ready), DW'(1));
    tick();
    in_valid = 1'b0;
    check_output("bp_next_valid", DW'(m_out_valid), DW'(1));
    check_output("bp_next_result", m_result, 32'd42);

    // Flush on the second shift cycle of the 1-bit unit
    sel       = 1'b1;
    operation = 4'd6;
    src_a     = 32'd3;
    src_b     = 32'd5;
    in_valid  = 1'b1;
    #1;
    tick();
    in_valid = 1'b0;
    tick();
    flush = 1'b1;
    #1;
    check_output("flush_ready_low", DW'(m_in_ready), DW'(0));
    tick();
    flush = 1'b0;
    #1;
    check_output("flush_valid", DW'(m_out_valid), DW'(0));
    check_output("flush_ready_back", DW'(m_in_ready), DW'(1));
    for (int k = 0; k < 6; k++) begin
      tick();
      check_output("flush_no_result", DW'(m_out_valid), DW'(0));
    end

    // Asynchronous reset in the middle of a shift clears the held result too
    operation = 4'd8;
    src_a     = 32'h8000_0000;
    src_b     = 32'd20;
    in_valid  = 1'b1;
    #1;
    tick();
    in_valid = 1'b0;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_output("arst_valid", DW'(m_out_valid), DW'(0));
    check_output("arst_result", m_result, '0);
    check_output("arst_branch", DW'(m_branch), DW'(0));
    check_output("arst_illegal", DW'(m_illegal), DW'(0));
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check_output("arst_quiet", DW'(m_out_valid), DW'(0));
    end

    for (int n = 0; n < 60; n++) begin
      logic [DW-1:0] ra;
      logic [DW-1:0] rb;
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
      apply_stimulus(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), ra, rb);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
